// File: rtl/agen_burst_sequencer_if.sv
// Request/access bundle between the AG stage and the burst sequencer; the
// sequencer uses the slave modport, the request source and ME side use master.
interface agen_burst_if #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 8
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic              req_v;
  logic              req_rdy;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] disp;
  logic [1:0]        scale;
  logic [15:0]       seg_base;
  logic [ADDR_W-1:0] seg_limit;
  logic [1:0]        mode;
  logic [1:0]        data_size;
  logic [CW-1:0]     beat_cnt;
  logic              flush;
  logic              acc_v;
  logic              acc_rdy;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_size;
  logic              acc_last;
  logic              exc_v;
  logic              done;
  logic [ADDR_W-1:0] final_off;

  modport master (
    output req_v, base, index, disp, scale, seg_base, seg_limit, mode,
           data_size, beat_cnt, flush, acc_rdy,
    input  req_rdy, acc_v, acc_addr, acc_size, acc_last, exc_v, done, final_off
  );

  modport slave (
    input  req_v, base, index, disp, scale, seg_base, seg_limit, mode,
           data_size, beat_cnt, flush, acc_rdy,
    output req_rdy, acc_v, acc_addr, acc_size, acc_last, exc_v, done, final_off
  );
endinterface

// File: rtl/agen_burst_sequencer.sv
// Multi-beat AG address sequencer: one EA request in, one linear access per beat out.
// Define AG_LINE_SPLIT_EN to split beats that cross a LINE_BYTES cache line.
module agen_burst_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 8
`ifdef AG_LINE_SPLIT_EN
  ,
  parameter int LINE_BYTES = 16
`endif
) (
  input logic          clk,
  input logic          rst_n,
  agen_burst_if.slave  bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);

`ifdef AG_LINE_SPLIT_EN
  localparam int LW = $clog2(LINE_BYTES);
  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] off_q, seg_limit_q, final_off_q;
  logic [15:0]       seg_base_q;
  logic [3:0]        size_q;
  logic              push_q;
  logic [CW-1:0]     beats_left_q;

  logic [ADDR_W-1:0] ea, lin_addr, next_off, acc_addr;
  logic [ADDR_W:0]   end_off;
  logic [3:0]        size_in, acc_size;
  logic [CW-1:0]     beats_in;
  logic              limit_fail, is_last, accept, advance;
  logic              acc_v, acc_last, exc_v, done, req_rdy;

  // Request-side operand formation and beat-count normalisation.
  always_comb begin
    ea      = bus.base + (bus.index << bus.scale) + bus.disp;
    size_in = 4'd1 << bus.data_size;
    if (bus.beat_cnt == '0)
      beats_in = CW'(1);
    else if (bus.beat_cnt > CW'(MAX_BEATS))
      beats_in = CW'(MAX_BEATS);
    else
      beats_in = bus.beat_cnt;
  end

  // The extra MSB on end_off makes an offset that wraps past 2^ADDR_W fail the limit check.
  assign lin_addr   = ADDR_W'({seg_base_q, 16'h0000}) + off_q;
  assign end_off    = {1'b0, off_q} + (ADDR_W+1)'(size_q) - (ADDR_W+1)'(1);
  assign limit_fail = end_off > {1'b0, seg_limit_q};
  assign next_off   = push_q ? off_q - ADDR_W'(size_q) : off_q + ADDR_W'(size_q);
  assign is_last    = beats_left_q == CW'(1);

`ifdef AG_LINE_SPLIT_EN
  logic [LW:0]       lo_sum;
  logic              crosses;
  logic [3:0]        first_size;
  logic [ADDR_W-1:0] split_addr;

  // off_q stays put across both halves, so the split is re-derived in SPLIT too.
  always_comb begin
    lo_sum     = {1'b0, lin_addr[LW-1:0]} + (LW+1)'(size_q);
    crosses    = lo_sum > (LW+1)'(LINE_BYTES);
    first_size = 4'((LW+1)'(LINE_BYTES) - {1'b0, lin_addr[LW-1:0]});
    split_addr = {lin_addr[ADDR_W-1:LW], {LW{1'b0}}} + ADDR_W'(LINE_BYTES);
  end
`endif

  // Next-state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    acc_v    = 1'b0;
    acc_addr = lin_addr;
    acc_size = size_q;
    acc_last = 1'b0;
    exc_v    = 1'b0;
    done     = 1'b0;
    req_rdy  = 1'b0;
    accept   = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_v) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (limit_fail) begin
          exc_v   = 1'b1;
          state_d = IDLE;
        end
`ifdef AG_LINE_SPLIT_EN
        else if (crosses) begin
          acc_v    = 1'b1;
          acc_size = first_size;
          if (bus.acc_rdy)
            state_d = SPLIT;
        end
`endif
        else begin
          acc_v    = 1'b1;
          acc_last = is_last;
          if (bus.acc_rdy) begin
            advance = 1'b1;
            if (is_last) begin
              done    = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
`ifdef AG_LINE_SPLIT_EN
      SPLIT: begin
        acc_v    = 1'b1;
        acc_addr = split_addr;
        acc_size = size_q - first_size;
        acc_last = is_last;
        if (bus.acc_rdy) begin
          advance = 1'b1;
          if (is_last) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d  = IDLE;
      acc_v    = 1'b0;
      acc_last = 1'b0;
      exc_v    = 1'b0;
      done     = 1'b0;
      req_rdy  = 1'b0;
      accept   = 1'b0;
      advance  = 1'b0;
    end
  end

  // Push pre-decrements, so the final push offset is the last beat's own offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      off_q        <= '0;
      seg_base_q   <= '0;
      seg_limit_q  <= '0;
      size_q       <= 4'd1;
      push_q       <= 1'b0;
      beats_left_q <= '0;
      final_off_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        push_q       <= bus.mode == 2'b01;
        size_q       <= size_in;
        off_q        <= (bus.mode == 2'b01) ? ea - ADDR_W'(size_in) : ea;
        beats_left_q <= beats_in;
        seg_base_q   <= bus.seg_base;
        seg_limit_q  <= bus.seg_limit;
      end else if (advance) begin
        off_q        <= next_off;
        beats_left_q <= beats_left_q - CW'(1);
        if (done)
          final_off_q <= push_q ? off_q : next_off;
      end
    end
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.acc_v     = acc_v;
  assign bus.acc_addr  = acc_addr;
  assign bus.acc_size  = acc_size;
  assign bus.acc_last  = acc_last;
  assign bus.exc_v     = exc_v;
  assign bus.done      = done;
  assign bus.final_off = final_off_q;
endmodule

// File: tb/tb_agen_burst_sequencer.sv
// Directed bench for agen_burst_sequencer: ascending, push, split, limit,
// backpressure/flush, beat-count edge cases and mid-burst reset.
module tb_agen_burst_sequencer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  agen_burst_if #(.ADDR_W(32), .MAX_BEATS(8)) bus();

  agen_burst_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request from IDLE and leaves the DUT in its first ISSUE cycle.
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] idx,
                               input logic [1:0] sc, input logic [31:0] d,
                               input logic [15:0] sg, input logic [31:0] lim,
                               input logic [1:0] md, input logic [1:0] ds,
                               input logic [3:0] cnt);
    bus.acc_rdy   = 1'b1;
    bus.flush     = 1'b0;
    bus.base      = b;
    bus.index     = idx;
    bus.scale     = sc;
    bus.disp      = d;
    bus.seg_base  = sg;
    bus.seg_limit = lim;
    bus.mode      = md;
    bus.data_size = ds;
    bus.beat_cnt  = cnt;
    bus.req_v     = 1'b1;
    #1;
    checkOutput("req_rdy_idle", bus.req_rdy, 1);
    step();
    bus.req_v = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_v     = 1'b0;
    bus.base      = '0;
    bus.index     = '0;
    bus.disp      = '0;
    bus.scale     = '0;
    bus.seg_base  = '0;
    bus.seg_limit = '0;
    bus.mode      = '0;
    bus.data_size = '0;
    bus.beat_cnt  = '0;
    bus.flush     = 1'b0;
    bus.acc_rdy   = 1'b0;
    #1;
    checkOutput("rst_req_rdy", bus.req_rdy, 1);
    checkOutput("rst_acc_v", bus.acc_v, 0);
    checkOutput("rst_exc_v", bus.exc_v, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_acc_last", bus.acc_last, 0);
    checkOutput("rst_final_off", bus.final_off, 32'h0);
    #11 rst_n = 1'b1;
    step();

    // Ascending: off0 = 0x100 + (2<<2) + 8 = 0x110, seg 0x0010 -> 0x0010_0110.
    applyStimulus(32'h100, 32'd2, 2'd2, 32'd8, 16'h0010, 32'hFFFF_FFFF, 2'b00, 2'd2, 4'd3);
    checkOutput("asc_b0_v", bus.acc_v, 1);
    checkOutput("asc_b0_addr", bus.acc_addr, 32'h0010_0110);
    checkOutput("asc_b0_size", bus.acc_size, 4);
    checkOutput("asc_b0_last", bus.acc_last, 0);
    step();
    checkOutput("asc_b1_addr", bus.acc_addr, 32'h0010_0114);
    checkOutput("asc_b1_done", bus.done, 0);
    step();
    checkOutput("asc_b2_addr", bus.acc_addr, 32'h0010_0118);
    checkOutput("asc_b2_last", bus.acc_last, 1);
    checkOutput("asc_b2_done", bus.done, 1);
    step();
    checkOutput("asc_idle_rdy", bus.req_rdy, 1);
    checkOutput("asc_idle_acc_v", bus.acc_v, 0);
    checkOutput("asc_final_off", bus.final_off, 32'h11C);

    // Push: 0x200 pre-decremented by 4 per beat.
    applyStimulus(32'h200, 32'd0, 2'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF, 2'b01, 2'd2, 4'd2);
    checkOutput("push_b0_addr", bus.acc_addr, 32'h1FC);
    checkOutput("push_b0_last", bus.acc_last, 0);
    step();
    checkOutput("push_b1_addr", bus.acc_addr, 32'h1F8);
    checkOutput("push_b1_last", bus.acc_last, 1);
    checkOutput("push_b1_done", bus.done, 1);
    step();
    checkOutput("push_final_off", bus.final_off, 32'h1F8);

    // Line crossing: offset 0x0E, 4 bytes.
    applyStimulus(32'h0E, 32'd0, 2'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF, 2'b00, 2'd2, 4'd1);
`ifdef AG_LINE_SPLIT_EN
    checkOutput("split_p0_addr", bus.acc_addr, 32'h0E);
    checkOutput("split_p0_size", bus.acc_size, 2);
    checkOutput("split_p0_last", bus.acc_last, 0);
    checkOutput("split_p0_done", bus.done, 0);
    step();
    checkOutput("split_p1_addr", bus.acc_addr, 32'h10);
    checkOutput("split_p1_size", bus.acc_size, 2);
    checkOutput("split_p1_last", bus.acc_last, 1);
    checkOutput("split_p1_done", bus.done, 1);
`else
    checkOutput("nosplit_addr", bus.acc_addr, 32'h0E);
    checkOutput("nosplit_size", bus.acc_size, 4);
    checkOutput("nosplit_last", bus.acc_last, 1);
    checkOutput("nosplit_done", bus.done, 1);
`endif
    step();
    checkOutput("split_final_off", bus.final_off, 32'h12);

    // Limit 0x107: beats at 0x100 and 0x104 pass, 0x108 faults.
    applyStimulus(32'h100, 32'd0, 2'd0, 32'd0, 16'h0000, 32'h107, 2'b00, 2'd2, 4'd3);
    checkOutput("lim_b0_addr", bus.acc_addr, 32'h100);
    checkOutput("lim_b0_v", bus.acc_v, 1);
    step();
    checkOutput("lim_b1_addr", bus.acc_addr, 32'h104);
    checkOutput("lim_b1_exc", bus.exc_v, 0);
    step();
    checkOutput("lim_b2_acc_v", bus.acc_v, 0);
    checkOutput("lim_b2_exc", bus.exc_v, 1);
    checkOutput("lim_b2_done", bus.done, 0);
    step();
    checkOutput("lim_rdy", bus.req_rdy, 1);
    checkOutput("lim_exc_pulse", bus.exc_v, 0);
    checkOutput("lim_final_off", bus.final_off, 32'h12);

    // Backpressure on beat 2, then flush.
    applyStimulus(32'h300, 32'd0, 2'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF, 2'b00, 2'd2, 4'd3);
    checkOutput("bp_b0_addr", bus.acc_addr, 32'h300);
    step();
    bus.acc_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_hold_v", bus.acc_v, 1);
      checkOutput("bp_hold_addr", bus.acc_addr, 32'h304);
      checkOutput("bp_hold_size", bus.acc_size, 4);
      checkOutput("bp_hold_last", bus.acc_last, 0);
      step();
    end
    bus.acc_rdy = 1'b1;
    bus.flush   = 1'b1;
    #1;
    checkOutput("flush_acc_v", bus.acc_v, 0);
    checkOutput("flush_done", bus.done, 0);
    step();
    bus.flush = 1'b0;
    #1;
    checkOutput("flush_idle_rdy", bus.req_rdy, 1);
    checkOutput("flush_idle_acc_v", bus.acc_v, 0);
    checkOutput("flush_final_off", bus.final_off, 32'h12);

    // Beat count 0 acts as 1; mode 11 acts as ascending.
    applyStimulus(32'h50, 32'd0, 2'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF, 2'b11, 2'd0, 4'd0);
    checkOutput("cnt0_addr", bus.acc_addr, 32'h50);
    checkOutput("cnt0_size", bus.acc_size, 1);
    checkOutput("cnt0_last", bus.acc_last, 1);
    checkOutput("cnt0_done", bus.done, 1);
    step();
    checkOutput("cnt0_final_off", bus.final_off, 32'h51);

    // Beat count 15 clamps to 8.
    applyStimulus(32'h60, 32'd0, 2'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF, 2'b00, 2'd0, 4'd15);
    for (int i = 0; i < 8; i++) begin
      checkOutput("clamp_addr", bus.acc_addr, 32'h60 + i);
      checkOutput("clamp_last", bus.acc_last, (i == 7) ? 1 : 0);
      step();
    end
    checkOutput("clamp_idle_rdy", bus.req_rdy, 1);
    checkOutput("clamp_final_off", bus.final_off, 32'h68);

    // Reset in the middle of a burst.
    applyStimulus(32'h400, 32'd0, 2'd0, 32'd0, 16'h0000, 32'hFFFF_FFFF, 2'b00, 2'd2, 4'd3);
    checkOutput("mid_acc_v", bus.acc_v, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_acc_v", bus.acc_v, 0);
    checkOutput("mid_rst_rdy", bus.req_rdy, 1);
    checkOutput("mid_rst_last", bus.acc_last, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_exc", bus.exc_v, 0);
    checkOutput("mid_rst_final_off", bus.final_off, 32'h0);
    #2 rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
